// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-map controller.
// Optional watchdog feature in the top level is enabled by defining SPI_CTRL_WDOG_EN.
package spi_ctrl_pkg;

    // Transaction tracking, driven by the synchronised chip select
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        QUERIED = 2'd2
    } txn_state_t;

    // Read-map bases
    localparam logic [7:0] Q_SRC    = 8'h00;
    localparam logic [7:0] Q_CFG    = 8'h10;
    localparam logic [7:0] Q_STATUS = 8'h20;

    // Write address 15 is the control register, never stored in the bank
    localparam logic [3:0] CTRL_ADDR = 4'hF;
    localparam int unsigned CFG_REGS = 16;

    // Returned for unmapped read addresses
    localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

    // One entry of the write-notify FIFO
    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_entry_t;

    // The status word only has a 3-bit level field; deeper FIFOs clamp at 7
    function automatic logic [2:0] level_field(input logic [31:0] level);
        return (level > 32'd7) ? 3'd7 : level[2:0];
    endfunction

endpackage

// File: rtl/spi_ctrl_wfifo.sv
// First-word-fall-through FIFO carrying {addr, data} write notifications.
// A pop and a push in the same cycle are both performed, even when full.
module spi_ctrl_wfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 36,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_pop;
    logic         do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = LW'(wptr - rptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so the outputs never show stale entries
    assign head = empty ? '0 : mem[rptr[AW-1:0]];

    // Read and write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Entry storage, no reset needed on the payload
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-map controller behind the SPI slave: serves reads from a frozen
// status snapshot / config bank / status word, commits writes into the bank
// and forwards them through a write-notify FIFO.
// Define SPI_CTRL_WDOG_EN to build in the write-activity watchdog.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WDOG_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_cs,
    input  logic                  ready,
    input  logic [7:0]            query,
    input  logic                  data_we,
    input  logic [3:0]            data_addr,
    input  logic [31:0]           data,
    output logic [31:0]           to_send,
    input  logic [NUM_SRC*32-1:0] src_data,
    output logic [16*32-1:0]      cfg_regs,
    output logic                  cfg_valid,
    output logic [3:0]            cfg_addr,
    output logic [31:0]           cfg_data,
    input  logic                  cfg_ready,
    output logic                  ovf_err,
    output logic                  wdog_trip
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    if (NUM_SRC < 1 || NUM_SRC > 16) begin : g_bad_num_src
        $error("spi_reg_ctrl: NUM_SRC must be 1..16");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_reg_ctrl: FIFO_DEPTH must be a power of 2 in 2..16");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("spi_reg_ctrl: WDOG_CYCLES must be at least 1");
    end

    logic [1:0]      cs_sync;
    logic            cs_s;
    txn_state_t      state;
    txn_state_t      state_next;
    logic            snap_load;
    logic [16*32-1:0] src_pad;
    logic [31:0]     snapshot [CFG_REGS];
    logic [31:0]     cfg [CFG_REGS];
    logic [15:0]     txn_cnt;
    logic [7:0]      wr_cnt;
    logic            ctrl_write;
    logic            cfg_write;
    logic            wr_blocked;
    logic            wdog_fire;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;
    wr_entry_t       push_entry;
    wr_entry_t       head;
    logic [31:0]     status_word;

    assign cs_s = cs_sync[1];

    // Two-flop synchroniser on the raw chip select; resets to deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_sync <= 2'b11;
        else        cs_sync <= {cs_sync[0], spi_cs};
    end

    // Transaction state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: deselect always wins, a ready in IDLE is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_s) state_next = ACTIVE;
            ACTIVE:  if (ready) state_next = QUERIED;
            QUERIED: state_next = QUERIED;
            default: state_next = IDLE;
        endcase
        if (cs_s) state_next = IDLE;
    end

    // Snapshot tracks the live sources only between frames
    always_comb begin
        snap_load = (state == IDLE);
    end

    // Unused source slots read as zero through the padded vector
    assign src_pad = (16*32)'(src_data);

    // Status snapshot, frozen for the duration of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) snapshot[i] <= '0;
        end else if (snap_load) begin
            for (int i = 0; i < 16; i++) snapshot[i] <= src_pad[32*i +: 32];
        end
    end

    // Write decode
    assign ctrl_write = data_we && (data_addr == CTRL_ADDR);
    assign cfg_write  = data_we && (data_addr != CTRL_ADDR) && !wr_blocked;
    assign push_entry = '{addr: data_addr, data: data};

`ifdef SPI_CTRL_WDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

    logic [WDW-1:0] wdog_cnt;
    logic           wdog_q;
    logic           wdog_clear;
    logic           wdog_reload;

    assign wdog_clear  = ctrl_write && data[1];
    assign wdog_reload = cfg_write || wdog_clear;
    assign wdog_fire   = !wdog_reload && (wdog_cnt == WDW'(1));
    // Motor command registers 0..3 are locked while the watchdog is tripped
    assign wr_blocked  = wdog_q && (data_addr < 4'd4);
    assign wdog_trip   = wdog_q;

    // Write-activity down-counter and sticky trip flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= WDW'(WDOG_CYCLES);
            wdog_q   <= 1'b0;
        end else begin
            if (wdog_reload)          wdog_cnt <= WDW'(WDOG_CYCLES);
            else if (wdog_cnt != '0)  wdog_cnt <= wdog_cnt - 1'b1;
            if (wdog_clear)           wdog_q <= 1'b0;
            else if (wdog_fire)       wdog_q <= 1'b1;
        end
    end
`else
    assign wdog_fire  = 1'b0;
    assign wr_blocked = 1'b0;
    assign wdog_trip  = 1'b0;
`endif

    // Config bank: committed writes, plus motor-command wipe on watchdog trip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) cfg[i] <= '0;
        end else begin
            if (cfg_write) cfg[data_addr] <= data;
            if (wdog_fire) begin
                for (int i = 0; i < 4; i++) cfg[i] <= '0;
            end
        end
    end

    // Sticky overflow: a push dropped because the FIFO is full and not draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    ovf_err <= 1'b0;
        else if (ctrl_write && data[0])                ovf_err <= 1'b0;
        else if (cfg_write && fifo_full && !cfg_ready) ovf_err <= 1'b1;
    end

    // Wrap-around transaction and write counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            if (ready)   txn_cnt <= txn_cnt + 1'b1;
            if (data_we) wr_cnt  <= wr_cnt + 1'b1;
        end
    end

    spi_ctrl_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wr_entry_t))
    ) u_wfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cfg_write),
        .push_data (push_entry),
        .pop       (cfg_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cfg_valid = !fifo_empty;
    assign cfg_addr  = head.addr;
    assign cfg_data  = head.data;

    for (genvar g = 0; g < 16; g++) begin : g_cfg_out
        assign cfg_regs[32*g +: 32] = cfg[g];
    end

    assign status_word = {txn_cnt, wr_cnt, 3'b000, wdog_trip, ovf_err,
                          level_field(32'(fifo_level))};

    // Read mux, purely combinational from query
    always_comb begin
        to_send = DEAD_WORD;
        if (query[7:4] == Q_SRC[7:4]) begin
            to_send = snapshot[query[3:0]];
        end else if (query[7:4] == Q_CFG[7:4]) begin
            to_send = (query[3:0] == CTRL_ADDR) ? 32'h0 : cfg[query[3:0]];
        end else if (query == Q_STATUS) begin
            to_send = status_word;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus a randomized
// write/read phase, checked against a transaction-level reference model.
module tb_spi_reg_ctrl;

    localparam int NSRC  = 6;
    localparam int DEPTH = 4;
    localparam int WD    = 100;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                spi_cs;
    logic                ready;
    logic [7:0]          query;
    logic                data_we;
    logic [3:0]          data_addr;
    logic [31:0]         data;
    logic [31:0]         to_send;
    logic [NSRC*32-1:0]  src_data;
    logic [16*32-1:0]    cfg_regs;
    logic                cfg_valid;
    logic [3:0]          cfg_addr;
    logic [31:0]         cfg_data;
    logic                cfg_ready;
    logic                ovf_err;
    logic                wdog_trip;

    spi_reg_ctrl #(
        .NUM_SRC     (NSRC),
        .FIFO_DEPTH  (DEPTH),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs    (spi_cs),
        .ready     (ready),
        .query     (query),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data      (data),
        .to_send   (to_send),
        .src_data  (src_data),
        .cfg_regs  (cfg_regs),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .ovf_err   (ovf_err),
        .wdog_trip (wdog_trip)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_cfg [16];
    logic [35:0] m_q [$];
    logic        m_ovf;
    logic        m_trip;
    logic [15:0] m_txn;
    logic [7:0]  m_wr;
    int          m_wcnt;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cfg[i] = '0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_trip = 1'b0;
        m_txn  = '0;
        m_wr   = '0;
        m_wcnt = WD;
    endtask

    // One clock of the specification's rules, using the inputs present at the edge
    task automatic model_step();
        logic blocked, commit, clr_trip, pop, was_full;
        if (!rst_n) return;
        blocked = 1'b0;
`ifdef SPI_CTRL_WDOG_EN
        blocked = m_trip && (data_addr < 4);
`endif
        commit   = data_we && (data_addr != 4'hF) && !blocked;
        clr_trip = data_we && (data_addr == 4'hF) && data[1];
        if (ready)   m_txn = m_txn + 16'd1;
        if (data_we) m_wr  = m_wr + 8'd1;
        if (commit)  m_cfg[data_addr] = data;
        if (data_we && data_addr == 4'hF && data[0]) m_ovf = 1'b0;
`ifdef SPI_CTRL_WDOG_EN
        if (commit || clr_trip) m_wcnt = WD;
        else if (m_wcnt > 0) begin
            m_wcnt--;
            if (m_wcnt == 0) begin
                m_trip = 1'b1;
                for (int i = 0; i < 4; i++) m_cfg[i] = '0;
            end
        end
        if (clr_trip) m_trip = 1'b0;
`else
        if (clr_trip) m_trip = 1'b0;
`endif
        was_full = (m_q.size() == DEPTH);
        pop = cfg_ready && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (commit) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else m_q.push_back({data_addr, data});
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = m_q.size();
        logic [2:0] l = (n > 7) ? 3'd7 : 3'(n);
        return {m_txn, m_wr, 3'b000, m_trip, m_ovf, l};
    endfunction

    // Expected read value while idle with src_data held steady
    function automatic logic [31:0] exp_read(input logic [7:0] q);
        if (q < 8'h10)       return (int'(q) < NSRC) ? src_data[32*int'(q) +: 32] : 32'h0;
        else if (q < 8'h1F)  return m_cfg[q[3:0]];
        else if (q == 8'h1F) return 32'h0;
        else if (q == 8'h20) return exp_status();
        else                 return 32'hDEAD_BEEF;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        query = a;
        #1;
        chk(tag, to_send, exp);
    endtask

    task automatic ready_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        query = a;
        ready = 1'b1;
        #1;
        chk(tag, to_send, exp);
        cycle();
        ready = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        data_we   = 1'b1;
        data_addr = a;
        data      = d;
        cycle();
        data_we   = 1'b0;
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "_valid"}, 32'(cfg_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, "_addr"}, 32'(cfg_addr), 32'(m_q[0][35:32]));
            chk({tag, "_data"}, cfg_data, m_q[0][31:0]);
        end
        chk({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; spi_cs = 1'b1; ready = 1'b0; query = '0;
        data_we = 1'b0; data_addr = '0; data = '0; src_data = '0; cfg_ready = 1'b0;
        model_reset();
        #12;
        // reset state
        chk("rst_cfg_valid", 32'(cfg_valid), 32'h0);
        chk("rst_cfg_addr",  32'(cfg_addr),  32'h0);
        chk("rst_cfg_data",  cfg_data,       32'h0);
        chk("rst_ovf",       32'(ovf_err),   32'h0);
        chk("rst_wdog",      32'(wdog_trip), 32'h0);
        chk("rst_cfg_lo",    cfg_regs[31:0], 32'h0);
        rd(8'h20, 32'h0, "rst_status");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Test 1: txn counter visible after one ready pulse
        spi_cs = 1'b0;
        repeat (4) cycle();
        ready_read(8'h20, 32'h0000_0000, "t1_status_pre");
        rd(8'h20, 32'h0001_0000, "t1_status_post");
        spi_cs = 1'b1;
        repeat (3) cycle();

        // Test 2: snapshot frozen during a frame, refreshed for the next
        src_data[64 +: 32] = 32'h1111;
        repeat (2) cycle();
        spi_cs = 1'b0;
        repeat (4) cycle();
        src_data[64 +: 32] = 32'h2222;
        cycle();
        ready_read(8'h02, 32'h1111, "t2_frozen");
        rd(8'h07, 32'h0, "t2_src_beyond_num");
        spi_cs = 1'b1;
        repeat (4) cycle();
        spi_cs = 1'b0;
        repeat (4) cycle();
        rd(8'h02, 32'h2222, "t2_next_frame");
        spi_cs = 1'b1;
        repeat (3) cycle();

        // Test 3: write commits to bank and appears at FIFO head
        cfg_ready = 1'b0;
        wr(4'd5, 32'hCAFE_0001);
        chk("t3_cfg5", cfg_regs[32*5 +: 32], 32'hCAFE_0001);
        chk("t3_valid", 32'(cfg_valid), 32'h1);
        chk("t3_addr", 32'(cfg_addr), 32'h5);
        rd(8'h15, 32'hCAFE_0001, "t3_read15");
        rd(8'h1F, 32'h0, "t3_read1f");
        rd(8'h21, 32'hDEAD_BEEF, "t3_read21");
        rd(8'hFF, 32'hDEAD_BEEF, "t3_readff");

        // Test 4: overflow, control clear, full FIFO with pop and push together
        cfg_ready = 1'b1;
        repeat (2) cycle();
        cfg_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(4'(6 + i), 32'hA000_0000 + i);
        chk("t4_no_ovf_at_depth", 32'(ovf_err), 32'h0);
        wr(4'd10, 32'hA000_0004);
        chk("t4_ovf_set", 32'(ovf_err), 32'h1);
        chk("t4_dropped_still_written", cfg_regs[32*10 +: 32], 32'hA000_0004);
        chk_fifo("t4_after_ovf");
        wr(4'hF, 32'h1);
        chk("t4_ovf_clr", 32'(ovf_err), 32'h0);
        query = 8'h20; #1;
        r = to_send;
        chk("t4_level4", 32'(r[2:0]), 32'h4);
        chk("t4_status", r, exp_status());
        cfg_ready = 1'b1;
        wr(4'd11, 32'hA000_0005);
        cfg_ready = 1'b0;
        chk("t4_simul_no_ovf", 32'(ovf_err), 32'h0);
        chk("t4_head_after_pop", 32'(cfg_addr), 32'h7);
        rd(8'h20, exp_status(), "t4_status2");

        // Randomized writes, reads, pops and idle ready pulses
        for (int k = 0; k < 300; k++) begin
            logic [7:0] q;
            cfg_ready = 1'($urandom_range(0, 1));
            data_we   = ($urandom_range(0, 2) != 0);
            data_addr = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            data      = $urandom;
            ready     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       q = 8'($urandom_range(0, 15));
                1:       q = 8'($urandom_range(16, 31));
                2:       q = 8'h20;
                default: q = 8'($urandom_range(33, 255));
            endcase
            rd(q, exp_read(q), "rnd_read");
            cycle();
            data_we = 1'b0;
            ready   = 1'b0;
            chk_fifo("rnd_fifo");
            begin
                int idx = $urandom_range(0, 15);
                chk("rnd_cfg_regs", cfg_regs[32*idx +: 32], m_cfg[idx]);
            end
        end
        cfg_ready = 1'b0;

`ifdef SPI_CTRL_WDOG_EN
        // Test 5: watchdog trip, locked motor registers, clear by control write
        @(posedge clk); #1;
        rst_n = 1'b0; model_reset();
        cycle(); rst_n = 1'b1; cycle();
        cfg_ready = 1'b1;
        wr(4'd1, 32'h7);
        repeat (99) cycle();
        chk("t5_not_yet", 32'(wdog_trip), 32'h0);
        cycle();
        chk("t5_trip", 32'(wdog_trip), 32'h1);
        chk("t5_cfg1_wiped", cfg_regs[32 +: 32], 32'h0);
        wr(4'd1, 32'h9);
        chk("t5_cfg1_locked", cfg_regs[32 +: 32], 32'h0);
        wr(4'hF, 32'h2);
        chk("t5_trip_clr", 32'(wdog_trip), 32'h0);
        wr(4'd1, 32'h9);
        chk("t5_cfg1_open", cfg_regs[32 +: 32], 32'h9);
        cfg_ready = 1'b0;
`else
        chk("t5_wdog_absent", 32'(wdog_trip), 32'h0);
`endif

        // Test 6: asynchronous reset mid-frame with FIFO holding entries
        wr(4'd2, 32'h0B0B_0002);
        wr(4'd3, 32'h0B0B_0003);
        spi_cs = 1'b0;
        repeat (4) cycle();
        ready_read(8'h20, exp_status(), "t6_status_pre");
        chk_fifo("t6_pre");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_valid", 32'(cfg_valid), 32'h0);
        chk("t6_async_cfg2", cfg_regs[64 +: 32], 32'h0);
        rd(8'h20, 32'h0, "t6_async_status");
        spi_cs = 1'b1;
        cycle(); cycle();
        rst_n = 1'b1;
        r = $urandom;
        src_data[0 +: 32] = r;
        repeat (2) cycle();
        rd(8'h00, r, "t6_idle_tracks_src");
        rd(8'h20, 32'h0, "t6_status_post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
